// File: rtl/root_hub_driver_pkg.sv
// Shared constants, result-field offsets and state type for root_hub_driver.
package root_hub_driver_pkg;

  localparam logic [7:0] BROADCAST_DEST          = 8'hff;
  localparam logic [7:0] START_DECODING_MSG      = 8'h01;
  localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

  localparam int CYC_LSB  = 24;
  localparam int CYC_MSB  = 39;
  localparam int ITER_LSB = 40;
  localparam int ITER_MSB = 47;

  localparam int MODE_SINGLE = 0;
  localparam int MODE_MULTI  = 1;
  localparam int MODE_ALT    = 2;
  localparam int MODE_MID    = 3;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_HEADER, ST_WAIT, ST_DONE} state_t;

  // Broadcast message word: dest, dest, opcode, zero payload, flag in bit 0.
  function automatic logic [63:0] msg_word(input logic [7:0] msg, input logic flag);
    msg_word = {BROADCAST_DEST, BROADCAST_DEST, msg, 39'd0, flag};
  endfunction

endpackage

// File: rtl/root_hub_driver_stats.sv
// Saturating cycle/iteration accumulators; min/max tracking when
// ROOT_HUB_DRIVER_STATS_EN is defined.
module root_hub_driver_stats
  import root_hub_driver_pkg::*;
#(
  parameter int STAT_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  accept,
  input  logic [15:0]           cycles,
  input  logic [7:0]            iterations,
  output logic [STAT_WIDTH-1:0] total_cycles,
  output logic [STAT_WIDTH-1:0] total_iterations
`ifdef ROOT_HUB_DRIVER_STATS_EN
  , output logic [15:0]         min_cycles
  , output logic [15:0]         max_cycles
  , output logic [7:0]          max_iterations
`endif
);

  logic [STAT_WIDTH:0] cyc_sum, iter_sum;

  // One extra bit catches the carry so the sum can clamp instead of wrapping.
  assign cyc_sum  = {1'b0, total_cycles}     + {{(STAT_WIDTH-15){1'b0}}, cycles};
  assign iter_sum = {1'b0, total_iterations} + {{(STAT_WIDTH-7){1'b0}}, iterations};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_cycles     <= '0;
      total_iterations <= '0;
    end else if (accept) begin
      total_cycles     <= cyc_sum[STAT_WIDTH]  ? '1 : cyc_sum[STAT_WIDTH-1:0];
      total_iterations <= iter_sum[STAT_WIDTH] ? '1 : iter_sum[STAT_WIDTH-1:0];
    end
  end

`ifdef ROOT_HUB_DRIVER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_cycles     <= 16'hffff;
      max_cycles     <= '0;
      max_iterations <= '0;
    end else if (accept) begin
      if (cycles < min_cycles)         min_cycles     <= cycles;
      if (cycles > max_cycles)         max_cycles     <= cycles;
      if (iterations > max_iterations) max_iterations <= iterations;
    end
  end
`endif

endmodule

// File: rtl/root_hub_driver.sv
// Round-based stimulus/measurement driver for the root hub local port.
// Optional min/max statistics ports under ROOT_HUB_DRIVER_STATS_EN.
module root_hub_driver
  import root_hub_driver_pkg::*;
#(
  parameter int CHANNEL_WIDTH  = 64,
  parameter int NUM_LEAVES     = 1,
  parameter int MAX_COUNT      = 1000,
  parameter int MODE           = 0,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int STAT_WIDTH     = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  output logic [CHANNEL_WIDTH-1:0] tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [CHANNEL_WIDTH-1:0] rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     done,
  output logic [31:0]              round_count,
  output logic [31:0]              result_count,
  output logic [15:0]              timeout_count,
  output logic [STAT_WIDTH-1:0]    total_cycles,
  output logic [STAT_WIDTH-1:0]    total_iterations
`ifdef ROOT_HUB_DRIVER_STATS_EN
  , output logic [15:0]            min_cycles
  , output logic [15:0]            max_cycles
  , output logic [7:0]             max_iterations
`endif
);

  state_t      state, state_nxt;
  logic [31:0] wd;
  logic [4:0]  per_round, exp_res;
  logic        multi, multi_nxt, accept, last, wd_fire, start_round;
  logic        unused_rx;

  assign unused_rx = ^{rx_data[CHANNEL_WIDTH-1:ITER_MSB+1], rx_data[CYC_LSB-1:0]};

  // Mode is decided on the round index before it increments.
  always_comb begin
    multi_nxt = 1'b0;
    case (MODE)
      MODE_MULTI: multi_nxt = 1'b1;
      MODE_ALT:   multi_nxt = round_count[0];
      MODE_MID:   multi_nxt = (round_count >= 32'(MAX_COUNT/3)) &&
                              (round_count <  32'(2*MAX_COUNT/3));
      default:    multi_nxt = 1'b0;
    endcase
  end

  assign exp_res = multi ? 5'd1 : 5'(NUM_LEAVES);
  assign accept  = (state == ST_WAIT) && rx_valid;
  assign last    = accept && (per_round + 5'd1 == exp_res);
  // An arriving result in the final watchdog cycle wins over the timeout.
  assign wd_fire = (TIMEOUT_CYCLES != 0) && (state == ST_WAIT) && !rx_valid &&
                   (wd == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = '0;
    rx_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (round_count == 32'(MAX_COUNT)) state_nxt = ST_DONE;
        else if (enable)                   state_nxt = ST_START;
      end
      ST_START: begin
        tx_valid      = 1'b1;
        tx_data[63:0] = msg_word(START_DECODING_MSG, multi);
        if (tx_ready) state_nxt = ST_HEADER;
      end
      ST_HEADER: begin
        tx_valid      = 1'b1;
        tx_data[63:0] = msg_word(MEASUREMENT_DATA_HEADER, 1'b0);
        if (tx_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        rx_ready = 1'b1;
        if (last || wd_fire) state_nxt = ST_IDLE;
      end
      ST_DONE:  rx_ready  = 1'b1;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign done        = (state == ST_DONE);
  assign start_round = (state == ST_IDLE) && (state_nxt == ST_START);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      round_count   <= '0;
      result_count  <= '0;
      timeout_count <= '0;
      multi         <= 1'b0;
      per_round     <= '0;
      wd            <= '0;
    end else begin
      state <= state_nxt;
      if (start_round) begin
        round_count <= round_count + 32'd1;
        multi       <= multi_nxt;
        per_round   <= '0;
      end
      if (state == ST_HEADER && tx_ready) wd <= '0;
      if (accept) begin
        per_round <= per_round + 5'd1;
        wd        <= '0;
      end else if (state == ST_WAIT) begin
        wd <= wd + 32'd1;
      end
      if (accept || (state == ST_DONE && rx_valid)) result_count <= result_count + 32'd1;
      if (wd_fire && timeout_count != 16'hffff) timeout_count <= timeout_count + 16'd1;
    end
  end

  root_hub_driver_stats #(.STAT_WIDTH(STAT_WIDTH)) u_stats (
    .clk              (clk),
    .reset            (reset),
    .accept           (accept),
    .cycles           (rx_data[CYC_MSB:CYC_LSB]),
    .iterations       (rx_data[ITER_MSB:ITER_LSB]),
    .total_cycles     (total_cycles),
    .total_iterations (total_iterations)
`ifdef ROOT_HUB_DRIVER_STATS_EN
    , .min_cycles     (min_cycles)
    , .max_cycles     (max_cycles)
    , .max_iterations (max_iterations)
`endif
  );

endmodule

// File: tb/tb_root_hub_driver.sv
// Directed bench for root_hub_driver: MODE=2, two leaves, four rounds, 8-cycle watchdog.
module tb_root_hub_driver;

  localparam int CW = 64;

  localparam logic [63:0] START0 = 64'hffff_0100_0000_0000;
  localparam logic [63:0] START1 = 64'hffff_0100_0000_0001;
  localparam logic [63:0] HDR    = 64'hffff_0200_0000_0000;

  logic          clk = 1'b0, reset = 1'b0, enable = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [CW-1:0] rx_data = '0;
  logic [CW-1:0] tx_data;
  logic          tx_valid, rx_ready, done;
  logic [31:0]   round_count, result_count;
  logic [15:0]   timeout_count;
  logic [47:0]   total_cycles, total_iterations;
`ifdef ROOT_HUB_DRIVER_STATS_EN
  logic [15:0]   min_cycles, max_cycles;
  logic [7:0]    max_iterations;
`endif

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  root_hub_driver #(
    .CHANNEL_WIDTH(CW), .NUM_LEAVES(2), .MAX_COUNT(4), .MODE(2),
    .TIMEOUT_CYCLES(8), .STAT_WIDTH(48)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .done(done), .round_count(round_count), .result_count(result_count),
    .timeout_count(timeout_count), .total_cycles(total_cycles),
    .total_iterations(total_iterations)
`ifdef ROOT_HUB_DRIVER_STATS_EN
    , .min_cycles(min_cycles), .max_cycles(max_cycles), .max_iterations(max_iterations)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs START (optionally stalled) and HEADER; returns at the HEADER negedge.
  task automatic start_hdr(input string tag, input bit flag, input int stall, input logic [31:0] rc);
    bit seen = 0;
    tx_ready = (stall == 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx_valid) begin seen = 1; break; end
    end
    check({tag, "_start_seen"}, 64'(seen), 64'd1);
    check({tag, "_start_word"}, tx_data, flag ? START1 : START0);
    check({tag, "_round_count"}, 64'(round_count), 64'(rc));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, 64'(tx_valid), 64'd1);
      check({tag, "_stall_data"}, tx_data, flag ? START1 : START0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check({tag, "_hdr_word"}, tx_data, HDR);
  endtask

  task automatic send(input logic [15:0] c, input logic [7:0] it);
    rx_data        = '0;
    rx_data[63:48] = 16'h5a5a;
    rx_data[23:0]  = 24'habcdef;
    rx_data[39:24] = c;
    rx_data[47:40] = it;
    rx_valid       = 1'b1;
    @(negedge clk);
    rx_valid       = 1'b0;
  endtask

  initial begin
    int cnt;
    #23;
    check("rst_round_count", 64'(round_count), 0);
    check("rst_result_count", 64'(result_count), 0);
    check("rst_timeout_count", 64'(timeout_count), 0);
    check("rst_total_cycles", 64'(total_cycles), 0);
    check("rst_done", 64'(done), 0);
    check("rst_tx_valid", 64'(tx_valid), 0);
    check("rst_rx_ready", 64'(rx_ready), 0);
    check("rst_tx_data", tx_data, 0);
`ifdef ROOT_HUB_DRIVER_STATS_EN
    check("rst_min_cycles", 64'(min_cycles), 64'hffff);
    check("rst_max_cycles", 64'(max_cycles), 0);
`endif
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;

    // Round 0: single mode, two results, START stalled 5 cycles
    start_hdr("r0", 1'b0, 5, 1);
    @(negedge clk);
    check("r0_rx_ready", 64'(rx_ready), 1);
    send(16'd7, 8'd2);
    send(16'd3, 8'd5);
    check("r0_exit", 64'(rx_ready), 0);
    check("r0_result_count", 64'(result_count), 2);

    // Round 1: multi mode, completes after one result
    start_hdr("r1", 1'b1, 0, 2);
    @(negedge clk);
    send(16'd12, 8'd1);
    check("r1_exit", 64'(rx_ready), 0);
    check("r1_total_cycles", 64'(total_cycles), 22);
    check("r1_total_iter", 64'(total_iterations), 8);
    check("r1_result_count", 64'(result_count), 3);
`ifdef ROOT_HUB_DRIVER_STATS_EN
    check("min_cycles", 64'(min_cycles), 3);
    check("max_cycles", 64'(max_cycles), 12);
    check("max_iterations", 64'(max_iterations), 5);
`endif

    // Round 2: no results, watchdog gives up after 8 WAIT cycles
    start_hdr("r2", 1'b0, 0, 3);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!rx_ready) break;
      cnt++;
    end
    check("wait_len", 64'(cnt), 8);
    check("timeout_count", 64'(timeout_count), 1);
    check("r2_result_count", 64'(result_count), 3);

    // Round 3: next START issued after timeout, multi again
    start_hdr("r3", 1'b1, 0, 4);
    @(negedge clk);
    send(16'd10, 8'd2);
    check("r3_exit", 64'(rx_ready), 0);
    repeat (3) @(negedge clk);
    check("done", 64'(done), 1);
    check("done_round_count", 64'(round_count), 4);
    check("done_result_count", 64'(result_count), 4);
    check("done_total_cycles", 64'(total_cycles), 32);
    check("done_total_iter", 64'(total_iterations), 10);
    check("done_tx_valid", 64'(tx_valid), 0);
    check("done_rx_ready", 64'(rx_ready), 1);

    // Late result in DONE: counted, not accumulated
    send(16'd100, 8'd9);
    check("drain_result_count", 64'(result_count), 5);
    check("drain_total_cycles", 64'(total_cycles), 32);
    check("drain_done", 64'(done), 1);

    // Fresh run, then reset mid-WAIT after one of two results
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    start_hdr("rs", 1'b0, 0, 1);
    @(negedge clk);
    send(16'd5, 8'd1);
    check("rs_in_wait", 64'(rx_ready), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_round_count", 64'(round_count), 0);
    check("arst_result_count", 64'(result_count), 0);
    check("arst_total_cycles", 64'(total_cycles), 0);
    check("arst_rx_ready", 64'(rx_ready), 0);
    check("arst_tx_valid", 64'(tx_valid), 0);
    check("arst_tx_data", tx_data, 0);
    @(negedge clk);
    reset = 1'b1;
    start_hdr("fresh", 1'b0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
